white_key_raster: RTL

Raster-side companion to the white-key bar decoder of the synthesizer VGA display. It accepts note-on/note-off events from the synth core over a valid/ready handshake and keeps a held-key bitmap, double-buffered so that updates only take effect at frame start. It tracks the VGA row stream incrementally, using counters rather than multipliers, and emits the registered one-hot key band for each row plus a "lit" flag, so the pixel mux can colour pressed white keys.

---
 rtl/white_key_pkg.sv | 37 +++
 rtl/white_key_held_map.sv | 97 +++++++++
 rtl/white_key_raster.sv | 135 +++++++++++++
 3 files changed

// File: rtl/white_key_pkg.sv
// Shared constants, note indices and row-tracker state encoding for the white-key raster.
package white_key_pkg;

  localparam int unsigned NUM_KEYS      = 15;
  localparam int unsigned BAND_H        = 32;
  localparam int unsigned Y_W           = 12;
  localparam int unsigned NOTE_W        = 4;
  localparam int unsigned OFS_W         = 5;
  localparam int unsigned BAND_LAST_ROW = NUM_KEYS * BAND_H - 1;

  localparam logic [NOTE_W-1:0] L_5 = 4'd0;
  localparam logic [NOTE_W-1:0] L_6 = 4'd1;
  localparam logic [NOTE_W-1:0] L_7 = 4'd2;
  localparam logic [NOTE_W-1:0] M_1 = 4'd3;
  localparam logic [NOTE_W-1:0] M_2 = 4'd4;
  localparam logic [NOTE_W-1:0] M_3 = 4'd5;
  localparam logic [NOTE_W-1:0] M_4 = 4'd6;
  localparam logic [NOTE_W-1:0] M_5 = 4'd7;
  localparam logic [NOTE_W-1:0] M_6 = 4'd8;
  localparam logic [NOTE_W-1:0] M_7 = 4'd9;
  localparam logic [NOTE_W-1:0] H_1 = 4'd10;
  localparam logic [NOTE_W-1:0] H_2 = 4'd11;
  localparam logic [NOTE_W-1:0] H_3 = 4'd12;
  localparam logic [NOTE_W-1:0] H_4 = 4'd13;
  localparam logic [NOTE_W-1:0] H_5 = 4'd14;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ACTIVE = 2'd1,
    BEYOND = 2'd2
  } row_state_e;

  function automatic logic [NUM_KEYS-1:0] note_onehot(input logic [NOTE_W-1:0] note);
    return NUM_KEYS'(1) << note;
  endfunction

endpackage

// File: rtl/white_key_held_map.sv
// Held-key shadow and frame-stable display bitmaps with the event handshake.
// WHITE_KEY_SUSTAIN_EN adds a sustain input that defers note-off until sustain drops.
module white_key_held_map
  import white_key_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                copy_stb,
  input  logic                ev_valid,
  input  logic [NOTE_W-1:0]   ev_note,
  input  logic                ev_on,
`ifdef WHITE_KEY_SUSTAIN_EN
  input  logic                sustain,
`endif
  output logic                ev_ready,
  output logic                ev_err,
  output logic [NUM_KEYS-1:0] shadow_map,
  output logic [NUM_KEYS-1:0] held_map
);

  logic                r_ready;
  logic                r_err;
  logic [NUM_KEYS-1:0] r_shadow;
  logic [NUM_KEYS-1:0] r_held;
  logic [NUM_KEYS-1:0] w_shadow_nx;
  logic                w_accept;
  logic                w_note_ok;

  assign w_accept  = ev_valid && r_ready;
  assign w_note_ok = (ev_note < NOTE_W'(NUM_KEYS));

`ifdef WHITE_KEY_SUSTAIN_EN
  logic                r_sus_d;
  logic [NUM_KEYS-1:0] r_pend;
  logic [NUM_KEYS-1:0] w_pend_nx;

  // Event is applied first; a sustain release then drops every pending note.
  always_comb begin
    w_shadow_nx = r_shadow;
    w_pend_nx   = r_pend;
    if (w_accept && w_note_ok) begin
      if (ev_on) begin
        w_shadow_nx[ev_note] = 1'b1;
        w_pend_nx[ev_note]   = 1'b0;
      end else if (sustain) begin
        w_pend_nx[ev_note] = 1'b1;
      end else begin
        w_shadow_nx[ev_note] = 1'b0;
      end
    end
    if (r_sus_d && !sustain) begin
      w_shadow_nx = w_shadow_nx & ~w_pend_nx;
      w_pend_nx   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sus_d <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_sus_d <= sustain;
      r_pend  <= w_pend_nx;
    end
  end
`else
  always_comb begin
    w_shadow_nx = r_shadow;
    if (w_accept && w_note_ok) begin
      w_shadow_nx[ev_note] = ev_on;
    end
  end
`endif

  // Display copy samples the pre-event shadow so a coincident event lands next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_shadow <= '0;
      r_held   <= '0;
    end else begin
      r_ready  <= 1'b1;
      r_err    <= w_accept && !w_note_ok;
      r_shadow <= w_shadow_nx;
      if (copy_stb) begin
        r_held <= r_shadow;
      end
    end
  end

  assign ev_ready   = r_ready;
  assign ev_err     = r_err;
  assign shadow_map = r_shadow;
  assign held_map   = r_held;

endmodule

// File: rtl/white_key_raster.sv
// Row tracker and key-band output mux for the white-key display.
// WHITE_KEY_SUSTAIN_EN adds the sustain input (passed to the held-map block).
module white_key_raster
  import white_key_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                row_stb,
  input  logic [Y_W-1:0]      CounterY,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic [NOTE_W-1:0]   ev_note,
  input  logic                ev_on,
`ifdef WHITE_KEY_SUSTAIN_EN
  input  logic                sustain,
`endif
  output logic                ev_err,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic                band_valid,
  output logic                key_lit,
  output logic [NUM_KEYS-1:0] held_map
);

  row_state_e          r_state;
  row_state_e          w_state_nx;
  logic [NOTE_W-1:0]   r_band;
  logic [NOTE_W-1:0]   w_band_nx;
  logic [NOTE_W-1:0]   w_note_nx;
  logic [OFS_W-1:0]    r_ofs;
  logic [OFS_W-1:0]    w_ofs_nx;
  logic [Y_W-1:0]      r_prev_y;
  logic [Y_W-1:0]      w_y_inc;
  logic                w_copy;
  logic [NUM_KEYS-1:0] w_shadow;
  logic [NUM_KEYS-1:0] w_disp_nx;
  logic [NUM_KEYS-1:0] r_onehot;
  logic [NUM_KEYS-1:0] w_onehot_nx;
  logic                r_bv;
  logic                w_bv_nx;
  logic                r_lit;
  logic                w_lit_nx;

  assign w_y_inc   = r_prev_y + Y_W'(1);
  assign w_copy    = row_stb && (CounterY == '0);
  assign w_disp_nx = w_copy ? w_shadow : held_map;

  white_key_held_map u_held_map (
    .clk        (clk),
    .reset      (reset),
    .copy_stb   (w_copy),
    .ev_valid   (ev_valid),
    .ev_note    (ev_note),
    .ev_on      (ev_on),
`ifdef WHITE_KEY_SUSTAIN_EN
    .sustain    (sustain),
`endif
    .ev_ready   (ev_ready),
    .ev_err     (ev_err),
    .shadow_map (w_shadow),
    .held_map   (held_map)
  );

  // Next row position and band outputs; everything holds between row strobes.
  always_comb begin
    w_state_nx  = r_state;
    w_band_nx   = r_band;
    w_ofs_nx    = r_ofs;
    w_note_nx   = '0;
    w_onehot_nx = r_onehot;
    w_bv_nx     = r_bv;
    w_lit_nx    = r_lit;
    if (row_stb) begin
      if (CounterY == '0) begin
        w_state_nx = ACTIVE;
        w_band_nx  = '0;
        w_ofs_nx   = '0;
      end else if (CounterY == w_y_inc) begin
        case (r_state)
          ACTIVE: begin
            if (r_ofs == OFS_W'(BAND_H - 1)) begin
              w_ofs_nx = '0;
              if (r_band == NOTE_W'(NUM_KEYS - 1)) begin
                w_state_nx = BEYOND;
              end else begin
                w_band_nx = r_band + NOTE_W'(1);
              end
            end else begin
              w_ofs_nx = r_ofs + OFS_W'(1);
            end
          end
          default: ;
        endcase
      end else begin
        w_state_nx = UNSYNC;
      end
      w_note_nx = NOTE_W'(NUM_KEYS - 1) - w_band_nx;
      if (w_state_nx == ACTIVE) begin
        w_onehot_nx = note_onehot(w_note_nx);
        w_bv_nx     = 1'b1;
        w_lit_nx    = w_disp_nx[w_note_nx];
      end else begin
        w_onehot_nx = '0;
        w_bv_nx     = 1'b0;
        w_lit_nx    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= UNSYNC;
      r_band   <= '0;
      r_ofs    <= '0;
      r_prev_y <= '0;
      r_onehot <= '0;
      r_bv     <= 1'b0;
      r_lit    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_band   <= w_band_nx;
      r_ofs    <= w_ofs_nx;
      r_onehot <= w_onehot_nx;
      r_bv     <= w_bv_nx;
      r_lit    <= w_lit_nx;
      if (row_stb) begin
        r_prev_y <= CounterY;
      end
    end
  end

  assign key_onehot = r_onehot;
  assign band_valid = r_bv;
  assign key_lit    = r_lit;

endmodule
